// File: rtl/alu_share_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_pkg
// Shared types and constants for the ALU sharing controller.
//   state_t   : controller FSM states (IDLE, EXEC, RESP)
//   alu_op_t  : ALU opcode type and the opcode constants the ALU implements
//   NUM_REQ   : number of requesters sharing the ALU
//   IDLE_SEL  : opcode driven to the ALU whenever no operation is executing
//   other_req : helper returning the id of the other requester
// ---------------------------------------------------------------------------
package alu_share_pkg;

    // Controller FSM states. IDLE arbitrates, EXEC drives the ALU for exactly
    // one cycle, RESP holds the captured result until the owner accepts it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] alu_op_t;

    // Opcodes understood by the shared ALU. The controller never decodes
    // these; they are listed here so sequencers and the ALU agree on them.
    localparam alu_op_t OP_ADD  = 3'b000;
    localparam alu_op_t OP_SUB  = 3'b001;
    localparam alu_op_t OP_AND  = 3'b010;
    localparam alu_op_t OP_OR   = 3'b011;
    localparam alu_op_t OP_NOT  = 3'b100;
    localparam alu_op_t OP_CLR  = 3'b101;
    localparam alu_op_t OP_PASS = 3'b111;

    localparam int      NUM_REQ  = 2;
    localparam alu_op_t IDLE_SEL = OP_CLR;

    // With only two requesters the "next in line" is simply the other one.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter with a one-bit priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : arbitration allowed this cycle (controller idle, out of reset)
//   req        : request vector, bit N = requester N valid
//   accept     : the granted request was handshaken this cycle
//   grant      : one-hot grant vector (all zero when disabled or no request)
//   grant_id   : index of the granted requester (valid when grant != 0)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import alu_share_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_id
);

    logic prio_q;

    // Grant selection. A lone requester always wins; when both are asking,
    // the priority pointer decides. Nothing is granted while disabled so the
    // ready outputs stay low outside IDLE and during reset.
    always_comb begin
        grant    = '0;
        grant_id = prio_q;
        if (enable) begin
            unique case (req)
                2'b01: begin
                    grant    = 2'b01;
                    grant_id = 1'b0;
                end
                2'b10: begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
                2'b11: begin
                    grant    = prio_q ? 2'b10 : 2'b01;
                    grant_id = prio_q;
                end
                default: begin
                    grant    = '0;
                    grant_id = prio_q;
                end
            endcase
        end
    end

    // Priority pointer. After every accepted request the pointer moves to the
    // requester that was not served, so a continuously requesting pair
    // alternates 0,1,0,1. Requests that are dropped without a handshake leave
    // the pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= other_req(grant_id);
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Shares one combinational ALU between two requesters. A granted request's
// operands are registered, driven to the ALU for one cycle, the result is
// captured and then returned on the owning requester's response channel.
// Only one operation is in flight at a time.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   reqN_valid/ready       : request handshake for requester N
//   reqN_a, reqN_b, reqN_sel : operands and opcode for requester N
//   rspN_valid/ready       : response handshake for requester N
//   rspN_data              : result for requester N (0 when not owned)
//   alu_a, alu_b, alu_sel  : drive to the external ALU
//   alu_out                : combinational ALU result
//   busy                   : controller is not idle
//   op_count               : completed responses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,

    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [SEL_W-1:0]   sel_q;
    logic               owner_q;
    logic [WIDTH-1:0]   result_q;
    logic [CNT_W-1:0]   count_q;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] grant;
    logic               grant_id;
    logic               arb_enable;
    logic               handshake;
    logic               rsp_accept;

    assign req_vec = {req1_valid, req0_valid};

    // The arbiter is also gated by rst_n so that both ready outputs drop to
    // zero the moment reset is asserted, even if a requester is still valid
    // (the FSM already sits in IDLE during reset and would otherwise grant).
    assign arb_enable = rst_n && (state_q == IDLE);

    rr_arbiter2 u_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (arb_enable),
        .req      (req_vec),
        .accept   (handshake),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign handshake  = |(req_vec & grant);
    assign rsp_accept = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    assign op_count   = count_q;

    // State register for the IDLE -> EXEC -> RESP -> IDLE loop. Reset drops
    // any in-flight operation on the spot; the result is simply abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. The ALU only sees real operands during
    // the single EXEC cycle; otherwise it is parked on the clear opcode with
    // zero operands. Only the owning response channel is ever valid, and the
    // other channel's data is forced to zero.
    always_comb begin
        state_d    = state_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = SEL_W'(IDLE_SEL);
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_data  = '0;
        rsp1_data  = '0;
        busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_sel = sel_q;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q) begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = result_q;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = result_q;
                end
                if (rsp_accept) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture on handshake. Once captured, the requester is free to
    // change or drop its inputs; the operation runs from these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= SEL_W'(IDLE_SEL);
            owner_q <= 1'b0;
        end else if (handshake) begin
            a_q     <= grant_id ? req1_a   : req0_a;
            b_q     <= grant_id ? req1_b   : req0_b;
            sel_q   <= grant_id ? req1_sel : req0_sel;
            owner_q <= grant_id;
        end
    end

    // Result capture at the end of the EXEC cycle; held through RESP no
    // matter how long the owner stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (state_q == EXEC) begin
            result_q <= alu_out;
        end
    end

    // Completed-response counter. It bumps when the owner takes the result
    // and wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (rsp_accept) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Scoreboard bench for alu_share_ctrl. Stimulus (directed plus random) is
// driven from the main initial block; a monitor process predicts every
// output from a transaction-level model and compares each cycle.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int WIDTH = 16;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [SEL_W-1:0] req0_sel, req1_sel;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_data, rsp1_data;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [SEL_W-1:0] alu_sel;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    typedef struct {
        logic             owner;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] result;
        int               exec_cycle;
    } txn_t;

    txn_t sb[$];
    int   total;
    int   bad;
    int   cycle;

    alu_share_ctrl #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Behavioural ALU; the same function gives the model its expected result
    // from the operands the requester presented at handshake time.
    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [SEL_W-1:0] sel);
        case (sel)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return ~a;
            3'b101:  return '0;
            3'b110:  return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb alu_out = alu_ref(alu_a, alu_b, alu_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, advanced on every active edge.
    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor / scoreboard. Each falling edge it predicts all DUT outputs
    // from the queue of accepted transactions, then retires a response that
    // is being accepted and enqueues a request that is being granted.
    initial begin
        logic             prio;
        logic [CNT_W-1:0] model_count;
        logic             exp_r0, exp_r1, exp_busy;
        logic             want_v0, want_v1;
        logic [WIDTH-1:0] want_d0, want_d1, want_a, want_b;
        logic [SEL_W-1:0] want_sel;
        txn_t             t;
        total       = 0;
        bad         = 0;
        prio        = 1'b0;
        model_count = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
                checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
                checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
                checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
                checkOutput("rst_rsp0_data", 32'(rsp0_data), 32'd0);
                checkOutput("rst_rsp1_data", 32'(rsp1_data), 32'd0);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_op_count", 32'(op_count), 32'd0);
                checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
                checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
                checkOutput("rst_alu_sel", 32'(alu_sel), 32'd5);
                sb.delete();
                prio        = 1'b0;
                model_count = '0;
            end else begin
                exp_busy = (sb.size() != 0);
                exp_r0   = 1'b0;
                exp_r1   = 1'b0;
                if (!exp_busy) begin
                    if (req0_valid && req1_valid) begin
                        exp_r0 = !prio;
                        exp_r1 = prio;
                    end else begin
                        exp_r0 = req0_valid;
                        exp_r1 = req1_valid;
                    end
                end
                want_v0  = 1'b0;
                want_v1  = 1'b0;
                want_d0  = '0;
                want_d1  = '0;
                want_a   = '0;
                want_b   = '0;
                want_sel = 3'b101;
                if (exp_busy) begin
                    t = sb[0];
                    if (cycle == t.exec_cycle) begin
                        want_a   = t.a;
                        want_b   = t.b;
                        want_sel = t.sel;
                    end else if (cycle > t.exec_cycle) begin
                        want_v0 = (t.owner == 1'b0);
                        want_v1 = (t.owner == 1'b1);
                        want_d0 = want_v0 ? t.result : '0;
                        want_d1 = want_v1 ? t.result : '0;
                    end
                end
                checkOutput("req0_ready", 32'(req0_ready), 32'(exp_r0));
                checkOutput("req1_ready", 32'(req1_ready), 32'(exp_r1));
                checkOutput("busy", 32'(busy), 32'(exp_busy));
                checkOutput("alu_a", 32'(alu_a), 32'(want_a));
                checkOutput("alu_b", 32'(alu_b), 32'(want_b));
                checkOutput("alu_sel", 32'(alu_sel), 32'(want_sel));
                checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(want_v0));
                checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(want_v1));
                checkOutput("rsp0_data", 32'(rsp0_data), 32'(want_d0));
                checkOutput("rsp1_data", 32'(rsp1_data), 32'(want_d1));
                checkOutput("op_count", 32'(op_count), 32'(model_count));

                if ((want_v0 && rsp0_ready) || (want_v1 && rsp1_ready)) begin
                    void'(sb.pop_front());
                    model_count = model_count + 1'b1;
                end
                if (exp_r0 || exp_r1) begin
                    t.owner      = exp_r1;
                    t.a          = exp_r1 ? req1_a : req0_a;
                    t.b          = exp_r1 ? req1_b : req0_b;
                    t.sel        = exp_r1 ? req1_sel : req0_sel;
                    t.result     = alu_ref(t.a, t.b, t.sel);
                    t.exec_cycle = cycle + 1;
                    sb.push_back(t);
                    prio = !exp_r1;
                end
            end
        end
    end

    // Presents one request, waits (bounded) for its grant, then drops valid
    // and scrambles the operands so only the captured copy can be correct.
    task automatic applyStimulus(input logic id, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [SEL_W-1:0] sel);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #2;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            $display("[TB] FAIL handshake_timeout: got no ready expected ready on req%0d", id);
            $fatal(1, "[TB] request never granted");
        end
        @(posedge clk);
        #2;
        if (id) begin
            req1_valid = 1'b0; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sel = 3'($urandom);
        end else begin
            req0_valid = 1'b0; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_sel = 3'($urandom);
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && !rsp0_valid && !rsp1_valid) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) begin
            $display("[TB] FAIL idle_timeout: got busy=%0d expected busy=0", busy);
            $fatal(1, "[TB] controller never returned to idle");
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        $display("[TB] single request from requester 0");
        applyStimulus(1'b0, 16'h0005, 16'h0003, OP_ADD);
        waitIdle();

        $display("[TB] both requesters valid from reset");
        doReset();
        req0_valid = 1'b1; req0_a = 16'h0010; req0_b = 16'h0001; req0_sel = OP_SUB;
        req1_valid = 1'b1; req1_a = 16'hFF0F; req1_b = 16'h0F0F; req1_sel = OP_AND;
        repeat (24) @(posedge clk);
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitIdle();

        $display("[TB] requester 1 stalls its response");
        rsp1_ready = 1'b0;
        applyStimulus(1'b1, 16'h1234, 16'h00FF, OP_AND);
        repeat (12) @(posedge clk);
        #2;
        rsp1_ready = 1'b1;
        waitIdle();

        $display("[TB] reset during EXEC");
        applyStimulus(1'b0, 16'hAAAA, 16'h5555, OP_OR);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);

        $display("[TB] operands scrambled after handshake");
        applyStimulus(1'b0, 16'h00F0, 16'h0F00, OP_OR);
        waitIdle();
        applyStimulus(1'b1, 16'h8000, 16'h0001, OP_NOT);
        waitIdle();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            req0_valid = 1'($urandom_range(0, 1));
            req0_a     = 16'($urandom);
            req0_b     = 16'($urandom);
            req0_sel   = 3'($urandom);
            req1_valid = 1'($urandom_range(0, 1));
            req1_a     = 16'($urandom);
            req1_b     = 16'($urandom);
            req1_sel   = 3'($urandom);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        waitIdle();
        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one combinational 16-bit ALU between two requesters using valid/ready handshakes and round-robin arbitration.
- Registers the granted request's operands, drives the external ALU for one cycle, captures the result, and returns it on the owning requester's response channel.
- Sits between the datapath sequencers and the single `alu` instance. Only one operation is in flight at a time.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- SEL_W, 3, ALU opcode width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 handshake accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  SEL_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 accepts the result.
- rsp0_data  out  WIDTH  result for requester 0.
- rsp1_valid, rsp1_ready, rsp1_data: same as requester 0, for requester 1.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_sel  out  SEL_W  opcode to the ALU.
- alu_out  in  WIDTH  combinational ALU result.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  CNT_W  completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state IDLE, priority pointer = requester 0.
  - All ready/valid outputs 0; rsp*_data 0; op_count 0; busy 0.
  - alu_a/alu_b 0; alu_sel 3'b101 (clear).
- States:
  - IDLE: arbitrate among valid requests.
  - EXEC: ALU driven from the operand registers.
  - RESP: result held until accepted.
- Arbitration (IDLE only, combinational):
  - Exactly one reqN_valid: grant N.
  - Both valid: grant the requester named by the priority pointer.
  - reqN_ready = (state==IDLE) && grant==N; never both high.
  - Handshake = reqN_valid && reqN_ready.
- On handshake:
  - Capture a, b, sel and owner id into internal registers.
  - Priority pointer flips to the non-granted requester.
  - Next state EXEC.
  - Requester inputs are ignored after the handshake.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_sel = registered values.
  - Result register <= alu_out at end of cycle; next state RESP.
- RESP:
  - rsp<owner>_valid = 1, rsp<owner>_data = result register; the other channel's valid stays 0.
  - On rsp<owner>_ready: op_count increments, next state IDLE.
  - With ready low: stall indefinitely; both req*_ready stay 0.
- ALU drive outside EXEC: alu_a/alu_b = 0, alu_sel = 3'b101.
- rsp*_data: rsp*_data of the non-owning channel is 0. Values are meaningful only while the matching valid is high.
- Latency and throughput:
  - Request handshake at cycle T gives rsp_valid at T+2.
  - Minimum spacing between accepted requests is 3 cycles.
- Opcodes are passed unmodified; the ALU owns their semantics. The controller does not decode opcodes.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-operation: immediate return to reset values; any in-flight result is discarded and no response is issued.
- Valid dropped without handshake: permitted, no effect.

Decomposition:
- Package alu_share_pkg holds:
  - typedef state_t {IDLE, EXEC, RESP};
  - typedef alu_op_t (SEL_W bits) with constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_NOT=100, OP_CLR=101, OP_PASS=111.
  - localparams NUM_REQ=2 and IDLE_SEL=OP_CLR.
- Sub-module rr_arbiter2: 2-input round-robin grant with pointer update on accept. The FSM, registers and counter stay in the top module.
- The ALU itself is instantiated outside this block.

Test Plan:
- Reset, then req0 only (a=0x0005, b=0x0003, sel=ADD) → req0_ready at T; alu_sel=000 at T+1; rsp0_valid with rsp0_data=0x0008 at T+2; op_count=1 after accept.
- Both valid continuously from reset (req0 SUB 0x0010,0x0001; req1 AND 0xFF0F,0x0F0F) → grants alternate 0,1,0,1; rsp0_data=0x000F and rsp1_data=0x0F0F; never both ready.
- rsp1_ready held low for 10 cycles in RESP → rsp1_valid and data stable, both req*_ready 0, busy 1; accept → IDLE next cycle.
- rst_n pulsed low during EXEC → all outputs at reset values asynchronously; no rsp_valid afterwards; op_count 0.
- Operands changed right after handshake (OR 0x00F0,0x0F00, then inputs scrambled) → rsp data 0x0FF0 from captured values; with CNT_W=4, 16 completions → op_count wraps to 0.
